// File: rtl/multi_channel_delay_pipe.sv
// multi_channel_delay_pipe: NCH-lane elastic delay line of DEPTH stages with
// a shared valid/ready handshake, flush, per-lane capture enable and counters.
module multi_channel_delay_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               NCH       = 2,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16,
    localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       chan_en,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]     occupancy,
    output logic [CNT_W-1:0]     count_out
);

    localparam int DW = NCH * WIDTH;

    logic [DEPTH-1:0] r_v;
    logic [DW-1:0]    r_d [DEPTH];
    logic [CNT_W-1:0] r_cnt;

    logic [DEPTH-1:0] w_mv;
    logic [DW-1:0]    w_in;
    logic             w_acc;
    logic             w_take;

    // room tracks whether the stage downstream is free or freeing
    always_comb begin : p_move
        logic room;
        room = out_ready;
        w_mv = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_mv[k] = r_v[k] & room;
            room    = ~r_v[k] | room;
        end
    end

    always_comb begin
        w_in = '0;
        for (int i = 0; i < NCH; i++) begin
            w_in[i*WIDTH +: WIDTH] = chan_en[i] ? in_data[i*WIDTH +: WIDTH]
                                                : RESET_VAL;
        end
    end

    // held low during reset so nothing is offered as accepted
    assign in_ready = rst_n & ~flush & (~r_v[0] | w_mv[0]);
    assign w_acc    = in_valid & in_ready;
    assign w_take   = r_v[DEPTH-1] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= {NCH{RESET_VAL}};
            end
        end else begin
            if (flush) begin
                r_v <= '0;
            end else begin
                r_v[0] <= w_acc | (r_v[0] & ~w_mv[0]);
                for (int k = 1; k < DEPTH; k++) begin
                    r_v[k] <= w_mv[k-1] | (r_v[k] & ~w_mv[k]);
                end
            end
            if (w_acc) begin
                r_d[0] <= w_in;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_mv[k-1]) begin
                    r_d[k] <= r_d[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_take) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(r_v[k]);
        end
    end

    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign count_out = r_cnt;

endmodule

// File: tb/tb_multi_channel_delay_pipe.sv
// Bench for multi_channel_delay_pipe: directed cases plus random valid/ready
// traffic checked against a timestamp-based queue model.
module tb_multi_channel_delay_pipe;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int D  = 3;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   chan_en;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic [1:0]     occupancy;
    logic [CW-1:0]  count_out;

    multi_channel_delay_pipe #(
        .WIDTH(W), .NCH(N), .DEPTH(D), .RESET_VAL(8'h00), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .chan_en(chan_en), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy), .count_out(count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] d;
        int             acc;
    } wrd_t;

    wrd_t q[$];
    int   n          = 0;
    int   last_leave = 0;
    int   mcnt       = 0;
    int   errs       = 0;
    int   checks     = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] masked(input logic [N*W-1:0] d,
                                              input logic [N-1:0] en);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (en[i]) r[i*W +: W] = d[i*W +: W];
        return r;
    endfunction

    // Head word reaches the output DEPTH-1 edges after acceptance, but never
    // before the edge at which its predecessor was taken.
    function automatic bit m_valid();
        int vis;
        if (q.size() == 0) return 1'b0;
        vis = q[0].acc + D - 1;
        if (last_leave > vis) vis = last_leave;
        return n >= vis;
    endfunction

    task automatic check_out();
        bit ov;
        ov = m_valid();
        chk("out_valid", 32'(out_valid), 32'(ov));
        if (ov) chk("out_data", 32'(out_data), 32'(q[0].d));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("count_out", 32'(count_out), 32'(mcnt % (1 << CW)));
    endtask

    task automatic cyc(input bit iv, input logic [N*W-1:0] data,
                       input logic [N-1:0] en, input bit ordy, input bit fl);
        bit exp_rdy, take, acc;
        in_valid  = iv;
        in_data   = data;
        chan_en   = en;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = rst_n && !fl && (q.size() < D || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        take = m_valid() && ordy;
        acc  = iv && exp_rdy;
        @(posedge clk);
        n++;
        if (take) begin
            void'(q.pop_front());
            mcnt++;
            last_leave = n;
        end
        if (fl) q.delete();
        if (acc) q.push_back('{masked(data, en), n});
        #1;
        check_out();
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, '0, '1, ordy, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        chan_en   = '1;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        check_out();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // single word latency
        cyc(1'b1, 16'h3CA5, 2'b11, 1'b1, 1'b0);
        idle(1'b1);
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        idle(1'b1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h3CA5);
        idle(1'b1);
        chk("t1_gone", 32'(out_valid), 32'd0);
        chk("t1_cnt", 32'(count_out), 32'd1);

        // back-to-back stream
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 16'(16'h0100 + i), 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("t2_cnt", 32'(count_out), 32'd11);

        // fill under stall, then drain
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 16'(16'h2200 + i), 2'b11, 1'b0, 1'b0);
        chk("t3_occ", 32'(occupancy), 32'd3);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // flush with occupancy 2 and an offered word
        cyc(1'b1, 16'h4401, 2'b11, 1'b0, 1'b0);
        cyc(1'b1, 16'h4402, 2'b11, 1'b0, 1'b0);
        chk("t4_occ2", 32'(occupancy), 32'd2);
        cyc(1'b1, 16'h4403, 2'b11, 1'b0, 1'b1);
        chk("t4_occ0", 32'(occupancy), 32'd0);
        chk("t4_ov", 32'(out_valid), 32'd0);
        idle(1'b1);

        // lane enable masking
        cyc(1'b1, 16'hFF11, 2'b01, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("t5_data", 32'(out_data), 32'h0011);
        idle(1'b1);

        // asynchronous reset with words held
        cyc(1'b1, 16'h6601, 2'b11, 1'b0, 1'b0);
        cyc(1'b1, 16'h6602, 2'b11, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        q.delete();
        mcnt = 0;
        check_out();
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 16'h6603, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // random traffic, count_out wraps several times
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) != 0, 16'($urandom),
                2'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 31) == 0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
